// File: rtl/mm_dp_scheduler.sv
// mm_dp_scheduler: sequences N_ENG dot-product engines over an M x N result
// matrix. Jobs (row,col) are issued in raster order to the lowest free slot,
// retired through each engine's start/done/ack handshake, and written to the
// result memory through a single round-robin arbitrated write port.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   go                     start request, sampled only while idle
//   m_rows/n_cols/k_len    matrix dimensions, latched on accepted go
//   busy, done             run in progress / one-cycle completion pulse
//   eng_start, eng_ack     per-engine handshake levels
//   eng_len                latched k_len shared by all engines
//   eng_row, eng_col       per-engine job indices, slot k at [k*DIM_W +: DIM_W]
//   eng_done, eng_acc      per-engine done level and accumulator
//   res_we/res_addr/res_data  registered result write port

// Per-engine slot: owns one engine's handshake and holds its result until
// the write arbiter takes it.
module mm_dp_slot #(
   parameter int DIM_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dispatch,
   input  logic [DIM_W-1:0]  job_row,
   input  logic [DIM_W-1:0]  job_col,
   input  logic              eng_done,
   input  logic [DATA_W-1:0] eng_acc,
   input  logic              grant,
   output logic              idle,
   output logic              pend,
   output logic              start,
   output logic              ack,
   output logic [DIM_W-1:0]  row,
   output logic [DIM_W-1:0]  col,
   output logic [DATA_W-1:0] result
);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_ACK_LO, S_ACK_HI} slot_state_t;

   slot_state_t state, state_nxt;
   logic        capture;

   assign capture = (state == S_RUN) && eng_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (dispatch) state_nxt = S_ARM;
         // one guaranteed low cycle on start so the engine sees a clean rising level
         S_ARM:    state_nxt = S_RUN;
         S_RUN:    if (eng_done) state_nxt = S_ACK_LO;
         S_ACK_LO: state_nxt = S_ACK_HI;
         // hold the slot until the engine has dropped done and the result is written
         S_ACK_HI: if (!eng_done && !pend) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      idle  = (state == S_IDLE);
      start = (state == S_RUN);
      ack   = (state != S_ACK_LO);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row    <= '0;
         col    <= '0;
         result <= '0;
         pend   <= 1'b0;
      end else begin
         if (dispatch && state == S_IDLE) begin
            row <= job_row;
            col <= job_col;
         end
         if (capture) result <= eng_acc;
         // capture only happens with pend clear, so set and clear never collide
         if (capture)    pend <= 1'b1;
         else if (grant) pend <= 1'b0;
      end
   end

endmodule

module mm_dp_scheduler #(
   parameter int N_ENG  = 4,
   parameter int DIM_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    go,
   input  logic [DIM_W-1:0]        m_rows,
   input  logic [DIM_W-1:0]        n_cols,
   input  logic [DIM_W-1:0]        k_len,
   output logic                    busy,
   output logic                    done,
   output logic [N_ENG-1:0]        eng_start,
   output logic [N_ENG-1:0]        eng_ack,
   output logic [DIM_W-1:0]        eng_len,
   output logic [N_ENG*DIM_W-1:0]  eng_row,
   output logic [N_ENG*DIM_W-1:0]  eng_col,
   input  logic [N_ENG-1:0]        eng_done,
   input  logic [N_ENG*DATA_W-1:0] eng_acc,
   output logic                    res_we,
   output logic [2*DIM_W-1:0]      res_addr,
   output logic [DATA_W-1:0]       res_data
);

   localparam int IDX_W  = (N_ENG > 1) ? $clog2(N_ENG) : 1;
   localparam int ADDR_W = 2 * DIM_W;

   typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} top_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   top_state_t top_state, top_nxt;

   logic [DIM_W-1:0] m_lat, n_lat, k_lat;
   logic [DIM_W-1:0] job_r, job_c;
   logic             all_disp, disp_ok, run_done;

   logic [N_ENG-1:0]             slot_idle, slot_pend, slot_disp, slot_gnt;
   logic [N_ENG-1:0][DIM_W-1:0]  slot_row, slot_col;
   logic [N_ENG-1:0][DATA_W-1:0] slot_res;

   logic             gnt_vld;
   logic [IDX_W-1:0] gnt_idx, rr_ptr;
   wr_req_t          wr_req, wr_q;

   // ---------------- top FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) top_state <= T_IDLE;
      else       top_state <= top_nxt;
   end

   always_comb begin
      top_nxt = top_state;
      case (top_state)
         T_IDLE:  if (go) top_nxt = T_RUN;
         T_RUN:   if (run_done) top_nxt = T_DONE;
         T_DONE:  top_nxt = T_IDLE;
         default: top_nxt = T_IDLE;
      endcase
   end

   always_comb begin
      busy = (top_state == T_RUN);
      done = (top_state == T_DONE);
   end

   // A zero-sized matrix counts as fully dispatched from the start.
   assign all_disp = (n_lat == '0) || (job_r >= m_lat);
   assign disp_ok  = (top_state == T_RUN) && !all_disp && (|slot_idle);
   // res_we is included so the final write leaves the port before done
   assign run_done = (top_state == T_RUN) && all_disp && (&slot_idle) &&
                     !(|slot_pend) && !res_we;

   // ---------------- dims and raster job counter ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_lat <= '0;
         n_lat <= '0;
         k_lat <= '0;
         job_r <= '0;
         job_c <= '0;
      end else if (top_state == T_IDLE && go) begin
         m_lat <= m_rows;
         n_lat <= n_cols;
         k_lat <= k_len;
         job_r <= '0;
         job_c <= '0;
      end else if (disp_ok) begin
         if (job_c == n_lat - DIM_W'(1)) begin
            job_c <= '0;
            job_r <= job_r + DIM_W'(1);
         end else begin
            job_c <= job_c + DIM_W'(1);
         end
      end
   end

   // lowest-index idle slot takes the job
   always_comb begin
      logic found;
      found     = 1'b0;
      slot_disp = '0;
      for (int i = 0; i < N_ENG; i++) begin
         if (disp_ok && !found && slot_idle[i]) begin
            slot_disp[i] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   // ---------------- write arbiter ----------------
   always_comb begin
      int j;
      j       = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < N_ENG; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= N_ENG) j = j - N_ENG;
         if (!gnt_vld && slot_pend[j]) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(j);
         end
      end
      slot_gnt = '0;
      if (gnt_vld) slot_gnt[gnt_idx] = 1'b1;
      wr_req.addr = ADDR_W'(slot_row[gnt_idx]) * ADDR_W'(n_lat) + ADDR_W'(slot_col[gnt_idx]);
      wr_req.data = slot_res[gnt_idx];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_we <= 1'b0;
         wr_q   <= '0;
         rr_ptr <= '0;
      end else begin
         res_we <= gnt_vld;
         if (gnt_vld) begin
            wr_q   <= wr_req;
            rr_ptr <= (int'(gnt_idx) == N_ENG - 1) ? '0 : gnt_idx + IDX_W'(1);
         end
      end
   end

   assign res_addr = wr_q.addr;
   assign res_data = wr_q.data;

   // ---------------- slots ----------------
   for (genvar k = 0; k < N_ENG; k++) begin : g_slot
      mm_dp_slot #(.DIM_W(DIM_W), .DATA_W(DATA_W)) u_slot (
         .clk      (clk),
         .reset    (reset),
         .dispatch (slot_disp[k]),
         .job_row  (job_r),
         .job_col  (job_c),
         .eng_done (eng_done[k]),
         .eng_acc  (eng_acc[k*DATA_W +: DATA_W]),
         .grant    (slot_gnt[k]),
         .idle     (slot_idle[k]),
         .pend     (slot_pend[k]),
         .start    (eng_start[k]),
         .ack      (eng_ack[k]),
         .row      (slot_row[k]),
         .col      (slot_col[k]),
         .result   (slot_res[k])
      );
   end

   assign eng_row = slot_row;
   assign eng_col = slot_col;
   assign eng_len = k_lat;

endmodule

// File: tb/tb_mm_dp_scheduler.sv
// Bench for mm_dp_scheduler: behavioural engines, write scoreboard, table of
// runs, randomized runs and hand sequences for the multi-cycle corner cases.
module tb_mm_dp_scheduler;

   localparam int N = 4;
   localparam int DW = 4;
   localparam int XW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            go;
   logic [DW-1:0]   m_rows, n_cols, k_len;
   logic            busy, done;
   logic [N-1:0]    eng_start, eng_ack, eng_done;
   logic [DW-1:0]   eng_len;
   logic [N*DW-1:0] eng_row, eng_col;
   logic [N*XW-1:0] eng_acc;
   logic            res_we;
   logic [2*DW-1:0] res_addr;
   logic [XW-1:0]   res_data;

   mm_dp_scheduler #(.N_ENG(N), .DIM_W(DW), .DATA_W(XW)) dut (
      .clk(clk), .reset(reset), .go(go), .m_rows(m_rows), .n_cols(n_cols), .k_len(k_len),
      .busy(busy), .done(done), .eng_start(eng_start), .eng_ack(eng_ack), .eng_len(eng_len),
      .eng_row(eng_row), .eng_col(eng_col), .eng_done(eng_done), .eng_acc(eng_acc),
      .res_we(res_we), .res_addr(res_addr), .res_data(res_data));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [XW-1:0] model_acc(input int r, input int c, input int k);
      if (k == 0) return '0;
      return 32'hA500_0000 ^ XW'(r << 16) ^ XW'(c << 8) ^ XW'(k << 2) ^ 32'h3;
   endfunction

   // ---------------- behavioural engines ----------------
   int           e_st[N];
   int           e_cnt[N];
   int           e_r[N], e_c[N], e_k[N];
   bit           seen_lo[N];
   logic [N-1:0] start_q;
   bit           force_mode = 0;
   bit           force_pulse = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            e_st[k] <= 0; e_cnt[k] <= 0; seen_lo[k] <= 0;
         end
         start_q  <= '0;
         eng_done <= '0;
         eng_acc  <= '0;
      end else begin
         start_q <= eng_start;
         for (int k = 0; k < N; k++) begin
            case (e_st[k])
               0: if (eng_start[k] && !start_q[k]) begin
                     e_st[k]  <= 1;
                     e_cnt[k] <= 0;
                     e_r[k]   <= int'(eng_row[k*DW +: DW]);
                     e_c[k]   <= int'(eng_col[k*DW +: DW]);
                     e_k[k]   <= int'(eng_len);
                  end
               1: begin
                     e_cnt[k] <= e_cnt[k] + 1;
                     if ((!force_mode && e_cnt[k] >= 2*e_k[k] + 2) || (force_mode && force_pulse)) begin
                        e_st[k]              <= 2;
                        eng_done[k]          <= 1'b1;
                        eng_acc[k*XW +: XW]  <= model_acc(e_r[k], e_c[k], e_k[k]);
                        seen_lo[k]           <= 0;
                     end
                  end
               default: if (!eng_ack[k]) seen_lo[k] <= 1;
                        else if (seen_lo[k]) begin
                           e_st[k]     <= 0;
                           eng_done[k] <= 1'b0;
                        end
            endcase
         end
      end
   end

   // ---------------- scoreboard / monitor ----------------
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   exp_m, exp_n, exp_k;
   int   wr_cnt, done_cnt;
   bit   seen[256];
   bit   any_start;
   int   wr_addr_q[$];
   int   wr_cyc_q[$];
   logic done_prev = 1'b0;
   logic [N-1:0] start_prev = '0;

   always @(negedge clk) begin
      if (!reset) begin
         if (res_we) begin
            wr_cnt++;
            wr_addr_q.push_back(int'(res_addr));
            wr_cyc_q.push_back(cyc);
            chk("wr_addr_range", int'(res_addr) < exp_m * exp_n, 1);
            if (exp_n > 0) begin
               chk("wr_unique", seen[res_addr], 0);
               chk("wr_data", res_data,
                   model_acc(int'(res_addr) / exp_n, int'(res_addr) % exp_n, exp_k));
            end
            seen[res_addr] = 1;
         end
         if (done) begin
            done_cnt++;
            chk("done_busy_low", busy, 0);
            chk("done_single", done_prev, 0);
         end
         for (int k = 0; k < N; k++)
            if (eng_start[k] && !start_prev[k]) chk("start_to_idle_engine", e_st[k], 0);
         if (|eng_start) any_start = 1;
      end
      done_prev  = done;
      start_prev = eng_start;
   end

   // ---------------- tasks ----------------
   task automatic launch(input int m, input int n, input int k);
      exp_m = m; exp_n = n; exp_k = k;
      wr_cnt = 0; done_cnt = 0; any_start = 0;
      for (int i = 0; i < 256; i++) seen[i] = 0;
      wr_addr_q.delete(); wr_cyc_q.delete();
      @(negedge clk);
      go = 1'b1; m_rows = DW'(m); n_cols = DW'(n); k_len = DW'(k);
      @(negedge clk);
      go = 1'b0;
      chk("busy_after_go", busy, 1);
      chk("eng_len", eng_len, DW'(k));
   endtask

   task automatic wait_done(input int budget, output int lat);
      lat = 1;
      while (!done && lat < budget) begin
         @(negedge clk);
         lat++;
      end
      chk("done_seen", done, 1);
      @(negedge clk);
   endtask

   task automatic finish_check(input int m, input int n);
      int hits;
      hits = 0;
      for (int i = 0; i < m * n; i++) hits += int'(seen[i]);
      chk("write_count", wr_cnt, m * n);
      chk("addr_coverage", hits, m * n);
      chk("done_count", done_cnt, 1);
      chk("busy_idle", busy, 0);
   endtask

   task automatic run(input int m, input int n, input int k, output int lat);
      launch(m, n, k);
      wait_done(60 + m * n * (2 * k + 14), lat);
      finish_check(m, n);
   endtask

   typedef struct {
      int m, n, k;
      int writes;
      int lat;   // -1: latency not checked
   } vec_t;

   vec_t tbl[8];
   int   lat;

   initial begin
      tbl[0] = '{2, 2, 3, 4, -1};
      tbl[1] = '{0, 5, 2, 0, 2};
      tbl[2] = '{5, 3, 2, 15, -1};
      tbl[3] = '{3, 0, 1, 0, 2};
      tbl[4] = '{1, 1, 0, 1, -1};
      tbl[5] = '{1, 7, 4, 7, -1};
      tbl[6] = '{15, 15, 1, 225, -1};
      tbl[7] = '{4, 1, 0, 4, -1};

      reset = 1'b1; go = 1'b0; m_rows = '0; n_cols = '0; k_len = '0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", res_we, 0);
      chk("rst_start", eng_start, '0);
      chk("rst_ack", eng_ack, 4'hF);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // all four engines report done together; arbiter pointer is 0 after reset
      force_mode = 1;
      launch(1, 4, 1);
      begin
         int t;
         t = 0;
         while (eng_start != 4'hF && t < 50) begin
            @(negedge clk);
            t++;
         end
         chk("force_all_running", eng_start, 4'hF);
      end
      @(negedge clk);
      force_pulse = 1;
      @(negedge clk);
      force_pulse = 0;
      wait_done(100, lat);
      finish_check(1, 4);
      if (wr_addr_q.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("force_order", wr_addr_q[i], i);
         for (int i = 1; i < 4; i++) chk("force_back_to_back", wr_cyc_q[i] - wr_cyc_q[i-1], 1);
      end else begin
         chk("force_write_log", wr_addr_q.size(), 4);
      end
      force_mode = 0;

      // table of whole runs
      for (int i = 0; i < 8; i++) begin
         run(tbl[i].m, tbl[i].n, tbl[i].k, lat);
         chk("tbl_writes", wr_cnt, tbl[i].writes);
         if (tbl[i].lat >= 0) begin
            chk("tbl_latency", lat, tbl[i].lat);
            chk("tbl_no_start", any_start, 0);
         end
         if (i == 0 && wr_cnt == 4) begin
            int s;
            s = 0;
            foreach (wr_addr_q[j]) s += wr_addr_q[j];
            chk("tbl0_addr_sum", s, 6);
         end
      end

      // randomized runs against the raster/address model
      for (int i = 0; i < 10; i++) begin
         int m, n, k;
         m = int'($urandom_range(0, 6));
         n = int'($urandom_range(0, 6));
         k = int'($urandom_range(0, 4));
         run(m, n, k, lat);
         if (m == 0 || n == 0) chk("rand_empty_latency", lat, 2);
      end

      // go while busy is ignored
      launch(3, 3, 2);
      repeat (10) @(negedge clk);
      chk("midgo_busy", busy, 1);
      go = 1'b1; m_rows = 4'd1; n_cols = 4'd1; k_len = 4'd0;
      @(negedge clk);
      go = 1'b0;
      chk("midgo_len_kept", eng_len, 4'd2);
      wait_done(300, lat);
      finish_check(3, 3);

      // reset in the middle of a run
      launch(3, 3, 3);
      repeat (12) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_we", res_we, 0);
      chk("midrst_start", eng_start, '0);
      chk("midrst_ack", eng_ack, 4'hF);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      begin
         int we_seen, dn_seen;
         we_seen = 0; dn_seen = 0;
         repeat (8) begin
            @(negedge clk);
            we_seen += int'(res_we);
            dn_seen += int'(done);
         end
         chk("midrst_no_write", we_seen, 0);
         chk("midrst_no_done", dn_seen, 0);
      end
      run(1, 1, 1, lat);
      if (wr_addr_q.size() > 0) chk("postrst_addr", wr_addr_q[0], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
